motor_slew_lim: RTL

Rate limiter between the flight-control pipeline and the ESC PWM block. On each flight-control update strobe it captures four 11-bit motor speed targets. It then moves each motor's output speed toward its target by at most MAX_STEP per update, using one shared step unit serialized over the four motors. When done it issues a single write strobe to the ESCs, so abrupt thrust commands never reach the motors as step changes.

---
 rtl/motor_slew_lim_pkg.sv | 21 ++
 rtl/motor_slew_lim_if.sv | 28 ++
 rtl/motor_slew_lim_step.sv | 32 +++
 rtl/motor_slew_lim.sv | 121 ++++++++++++
 4 files changed

// File: rtl/motor_slew_lim_pkg.sv
// Shared types and constants for the motor slew-rate limiter.
package motor_slew_pkg;

    localparam int SPD_W        = 11;
    localparam int MAX_STEP_DEF = 64;

    typedef logic [SPD_W-1:0] spd_t;

    typedef enum logic {
        IDLE = 1'b0,
        STEP = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        FRNT = 2'd0,
        BCK  = 2'd1,
        LFT  = 2'd2,
        RGHT = 2'd3
    } motor_idx_t;

endpackage

// File: rtl/motor_slew_lim_if.sv
// Bus between the flight-control pipeline (master) and the slew limiter (slave).
interface motor_slew_lim_if;
    import motor_slew_pkg::*;

    logic wrt_in;
    spd_t frnt_tgt;
    spd_t bck_tgt;
    spd_t lft_tgt;
    spd_t rght_tgt;
    logic motors_off;
    spd_t frnt_spd;
    spd_t bck_spd;
    spd_t lft_spd;
    spd_t rght_spd;
    logic wrt;
    logic busy;

    modport master (
        output wrt_in, frnt_tgt, bck_tgt, lft_tgt, rght_tgt, motors_off,
        input  frnt_spd, bck_spd, lft_spd, rght_spd, wrt, busy
    );

    modport slave (
        input  wrt_in, frnt_tgt, bck_tgt, lft_tgt, rght_tgt, motors_off,
        output frnt_spd, bck_spd, lft_spd, rght_spd, wrt, busy
    );

endinterface

// File: rtl/motor_slew_lim_step.sv
// Combinational step unit: moves one speed toward its target by at most MAX_STEP.
module slew_step
    import motor_slew_pkg::*;
#(
    parameter int MAX_STEP = MAX_STEP_DEF
) (
    input  spd_t cur_i,
    input  spd_t tgt_i,
    output spd_t nxt_o,
    output logic clamped_o
);

    localparam logic signed [SPD_W:0] StepPos = (SPD_W+1)'(MAX_STEP);
    localparam spd_t                  StepMag = SPD_W'(MAX_STEP);

    logic signed [SPD_W:0] delta;

    // The result always lies between current and target, so no saturation is needed.
    always_comb begin
        delta     = $signed({1'b0, tgt_i}) - $signed({1'b0, cur_i});
        nxt_o     = tgt_i;
        clamped_o = 1'b0;
        if (delta > StepPos) begin
            nxt_o     = cur_i + StepMag;
            clamped_o = 1'b1;
        end else if (delta < -StepPos) begin
            nxt_o     = cur_i - StepMag;
            clamped_o = 1'b1;
        end
    end

endmodule

// File: rtl/motor_slew_lim.sv
// Slew-rate limiter between flight control and the ESCs; one shared step unit
// walks the four motors in turn. Optional macro SLEW_CLAMP_CNT_EN adds clamp_cnt.
module motor_slew_lim
    import motor_slew_pkg::*;
#(
    parameter int MAX_STEP = MAX_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    motor_slew_lim_if.slave   bus
`ifdef SLEW_CLAMP_CNT_EN
    ,
    output logic [15:0]       clamp_cnt
`endif
);

    state_t           state_q, state_d;
    motor_idx_t       idx_q, idx_d;
    spd_t [3:0]       spd_q, spd_d;
    spd_t [3:0]       tgt_q, tgt_d;
    logic             wrt_q, wrt_d;

    spd_t             stepCur;
    spd_t             stepTgt;
    spd_t             stepNxt;
    logic             stepClamped;

    assign stepCur = spd_q[idx_q];
    assign stepTgt = tgt_q[idx_q];

    slew_step #(
        .MAX_STEP (MAX_STEP)
    ) u_step (
        .cur_i     (stepCur),
        .tgt_i     (stepTgt),
        .nxt_o     (stepNxt),
        .clamped_o (stepClamped)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= FRNT;
            spd_q   <= '0;
            tgt_q   <= '0;
            wrt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            spd_q   <= spd_d;
            tgt_q   <= tgt_d;
            wrt_q   <= wrt_d;
        end
    end

    // motors_off overrides everything; new targets are only sampled while IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        spd_d   = spd_q;
        tgt_d   = tgt_q;
        wrt_d   = 1'b0;
        if (bus.motors_off) begin
            state_d = IDLE;
            idx_d   = FRNT;
            spd_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.wrt_in) begin
                        tgt_d[FRNT] = bus.frnt_tgt;
                        tgt_d[BCK]  = bus.bck_tgt;
                        tgt_d[LFT]  = bus.lft_tgt;
                        tgt_d[RGHT] = bus.rght_tgt;
                        idx_d       = FRNT;
                        state_d     = STEP;
                    end
                end
                STEP: begin
                    spd_d[idx_q] = stepClamped ? stepNxt : stepTgt;
                    idx_d        = motor_idx_t'(idx_q + 2'd1);
                    if (idx_q == RGHT) begin
                        wrt_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef SLEW_CLAMP_CNT_EN
    logic [15:0] clamp_q, clamp_d;

    // Survives motors_off so the count reflects the whole flight.
    always_comb begin
        clamp_d = clamp_q;
        if (!bus.motors_off && state_q == STEP && stepClamped && clamp_q != 16'hFFFF) begin
            clamp_d = clamp_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clamp_q <= '0;
        end else begin
            clamp_q <= clamp_d;
        end
    end

    assign clamp_cnt = clamp_q;
`endif

    assign bus.frnt_spd = spd_q[FRNT];
    assign bus.bck_spd  = spd_q[BCK];
    assign bus.lft_spd  = spd_q[LFT];
    assign bus.rght_spd = spd_q[RGHT];
    assign bus.wrt      = wrt_q;
    assign bus.busy     = (state_q != IDLE);

endmodule
